// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory request/grant/response channel,
// decode-side instruction handshake and the next-PC exchange.
interface if_fetch_unit_if;
    logic        redirect;
    logic [31:0] npc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;

    // Fetch unit side.
    modport master (
        input  redirect, npc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, instr_out, pc_out, pc_plus4
    );

    // Memory / decode / next-PC side.
    modport slave (
        output redirect, npc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, instr_out, pc_out, pc_plus4
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, keeps at most one
// instruction-memory read in flight, and hands the fetched word plus its PC
// to decode. A redirect that lands while a read is in flight marks that read
// as killed so its data is drained and dropped rather than presented.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic            clk,
    input  logic            rst_n,
    if_fetch_unit_if.master fetch_bus
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e      state_q;
    logic [31:0] fetch_pc_q;
    logic        kill_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;

    logic [31:0] npc_aligned;
    logic [31:0] fetch_pc_inc;
    logic        unused_npc_bits;

    // Redirect targets are always word aligned; the low bits are dropped.
    assign npc_aligned     = {fetch_bus.npc[31:2], 2'b00};
    assign unused_npc_bits = ^fetch_bus.npc[1:0];
    assign fetch_pc_inc    = fetch_pc_q + 32'd4;

    // Fetch control FSM together with the fetch PC, kill flag and the
    // instruction/PC holding registers presented to decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            kill_q     <= 1'b0;
            instr_q    <= 32'd0;
            pc_q       <= 32'd0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= REQ;
                end
                REQ: begin
                    // A redirect always retargets the fetch PC; if the old
                    // request was granted in the same cycle it is already
                    // out, so its response must be killed.
                    if (fetch_bus.redirect) begin
                        fetch_pc_q <= npc_aligned;
                    end
                    if (fetch_bus.imem_gnt) begin
                        kill_q  <= fetch_bus.redirect;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (fetch_bus.imem_rvalid) begin
                        if (kill_q || fetch_bus.redirect) begin
                            kill_q  <= 1'b0;
                            state_q <= REQ;
                            if (fetch_bus.redirect) begin
                                fetch_pc_q <= npc_aligned;
                            end
                        end else begin
                            instr_q    <= fetch_bus.imem_rdata;
                            pc_q       <= fetch_pc_q;
                            fetch_pc_q <= fetch_pc_inc;
                            state_q    <= HOLD;
                        end
                    end else if (fetch_bus.redirect) begin
                        kill_q     <= 1'b1;
                        fetch_pc_q <= npc_aligned;
                    end
                end
                HOLD: begin
                    // Redirect wins over ready: the held instruction is on
                    // the wrong path and is dropped.
                    if (fetch_bus.redirect) begin
                        fetch_pc_q <= npc_aligned;
                        state_q    <= REQ;
                    end else if (fetch_bus.instr_ready) begin
                        state_q <= REQ;
                    end
                end
                default: begin
                    state_q <= BOOT;
                end
            endcase
        end
    end

    assign fetch_bus.imem_req    = (state_q == REQ);
    assign fetch_bus.imem_addr   = fetch_pc_q;
    assign fetch_bus.instr_valid = (state_q == HOLD);
    assign fetch_bus.instr_out   = instr_q;
    assign fetch_bus.pc_out      = pc_q;
    assign fetch_bus.pc_plus4    = pc_q + 32'd4;

endmodule
